// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 BIST wrapper.
package s27_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } bist_state_t;

  localparam logic [7:0]  LFSR_POLY_DEF = 8'hB8;
  localparam logic [7:0]  LFSR_SEED_DEF = 8'h01;
  localparam logic [15:0] MISR_POLY_DEF = 16'h8016;

  // Bit positions of the s27 state flops inside core_state / core_ns.
  localparam int unsigned G5 = 0;
  localparam int unsigned G6 = 1;
  localparam int unsigned G7 = 2;

endpackage

// File: rtl/s27_lfsr.sv
// Generic right-shifting Galois LFSR with synchronous load and enable.
// Only the low TAP_W bits are exported as the stimulus pattern.
module s27_lfsr
  import s27_bist_pkg::*;
#(
  parameter int unsigned       W     = 8,
  parameter int unsigned       TAP_W = 4,
  parameter logic [W-1:0]      POLY  = W'(LFSR_POLY_DEF)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             enable,
  input  logic [W-1:0]     seed,
  output logic [TAP_W-1:0] tap
);

  logic [W-1:0] lfsr_q;

  // Reset and load both restart from the seed; enable advances one step.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lfsr_q <= seed;
    end else if (load) begin
      lfsr_q <= seed;
    end else if (enable) begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    end
  end

  assign tap = lfsr_q[TAP_W-1:0];

endmodule

// File: rtl/s27_bist_wrap.sv
// Sequential BIST wrapper around the combinational s27 core: owns the three
// state flops, muxes pin/LFSR stimulus into G0..G3 and compacts the core
// response into a MISR signature.
// Optional scan chain through the state flops: define S27_SCAN_EN.
module s27_bist_wrap
  import s27_bist_pkg::*;
#(
  parameter int unsigned        LFSR_W    = 8,
  parameter logic [LFSR_W-1:0]  LFSR_POLY = LFSR_W'(LFSR_POLY_DEF),
  parameter logic [LFSR_W-1:0]  LFSR_SEED = LFSR_W'(LFSR_SEED_DEF),
  parameter int unsigned        MISR_W    = 16,
  parameter logic [MISR_W-1:0]  MISR_POLY = MISR_W'(MISR_POLY_DEF),
  parameter int unsigned        PATTERNS  = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        pi,
  output logic [3:0]        core_pi,
  output logic [2:0]        core_state,
  input  logic [2:0]        core_ns,
  input  logic              core_po,
  output logic              po,
`ifdef S27_SCAN_EN
  input  logic              scan_en,
  input  logic              scan_in,
  output logic              scan_out,
`endif
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature,
  output logic [7:0]        pat_cnt
);

  if (PATTERNS < 1 || PATTERNS > 255) begin : g_bad_patterns
    $error("s27_bist_wrap: PATTERNS must be in 1..255");
  end
  if (LFSR_W < 4) begin : g_bad_lfsr_w
    $error("s27_bist_wrap: LFSR_W must be >= 4");
  end
  if (MISR_W < 4) begin : g_bad_misr_w
    $error("s27_bist_wrap: MISR_W must be >= 4");
  end

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
  localparam logic [7:0] LAST_CNT = 8'(PATTERNS - 1);

  bist_state_t       state_q, state_d;
  logic [2:0]        st_q;
  logic [MISR_W-1:0] misr_q;
  logic [7:0]        cnt_q;
  logic [3:0]        lfsr_tap;
  logic              in_init, in_run;

  assign in_init = (state_q == INIT);
  assign in_run  = (state_q == RUN);

  s27_lfsr #(
    .W     (LFSR_W),
    .TAP_W (4),
    .POLY  (LFSR_POLY)
  ) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (in_init),
    .enable  (in_run),
    .seed    (SEED_EFF),
    .tap     (lfsr_tap)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status outputs; start is only looked at in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = INIT;
      INIT: begin
        busy    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // s27 state flops: cleared in INIT, otherwise capture the core next-state
  // (or shift the scan chain while idle when scan is built in).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st_q <= '0;
    end else if (in_init) begin
      st_q <= '0;
`ifdef S27_SCAN_EN
    end else if (state_q == IDLE && scan_en) begin
      st_q[G7] <= st_q[G6];
      st_q[G6] <= st_q[G5];
      st_q[G5] <= scan_in;
`endif
    end else begin
      st_q[G5] <= core_ns[G5];
      st_q[G6] <= core_ns[G6];
      st_q[G7] <= core_ns[G7];
    end
  end

  // MISR compaction and pattern counter; both hold outside INIT/RUN.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      misr_q <= '0;
      cnt_q  <= '0;
    end else if (in_init) begin
      misr_q <= '0;
      cnt_q  <= '0;
    end else if (in_run) begin
      misr_q <= (misr_q << 1) ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
                ^ MISR_W'({core_po, core_ns});
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign core_pi    = (in_init || in_run) ? lfsr_tap : pi;
  assign core_state = st_q;
  assign po         = core_po;
  assign signature  = misr_q;
  assign pat_cnt    = cnt_q;
`ifdef S27_SCAN_EN
  assign scan_out   = st_q[G7];
`endif

endmodule

// File: tb/tb_s27_bist_wrap.sv
// Randomized scoreboard bench for s27_bist_wrap. The bench plays the s27 core
// by driving random core_ns/core_po, tracks the run as a position within the
// BIST timeline, and compares every DUT output after each clock edge.
module tb_s27_bist_wrap;

  localparam int P    = 20;
  localparam int NCYC = 3000;
  localparam logic [7:0]  SEED_EFF = 8'h01;
  localparam logic [7:0]  LPOLY    = 8'hB8;
  localparam logic [15:0] MPOLY    = 16'h8016;

  logic        clock = 1'b0;
  logic        reset_n, start, core_po;
  logic [3:0]  pi;
  logic [2:0]  core_ns;
  logic [3:0]  core_pi;
  logic [2:0]  core_state;
  logic        po, busy, done;
  logic [15:0] signature;
  logic [7:0]  pat_cnt;
`ifdef S27_SCAN_EN
  logic        scan_en, scan_in, scan_out;
`endif

  always #5 clock = ~clock;

  s27_bist_wrap #(
    .LFSR_SEED (8'h00),
    .PATTERNS  (P)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .pi         (pi),
    .core_pi    (core_pi),
    .core_state (core_state),
    .core_ns    (core_ns),
    .core_po    (core_po),
    .po         (po),
`ifdef S27_SCAN_EN
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
`endif
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .pat_cnt    (pat_cnt)
  );

  typedef struct {
    logic [3:0]  cpi;
    logic [2:0]  cst;
    logic        bsy;
    logic        dn;
    logic        p;
    logic [15:0] sg;
    logic [7:0]  pc;
    logic        so;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: pos 0 = idle, 1 = init, 2..P+1 = capture cycles, P+2 = done.
  int          pos = 0;
  logic [2:0]  st;
  logic [7:0]  lf;
  logic [15:0] sg;
  int          pc;

  function automatic logic [7:0] lstep(input logic [7:0] x);
    return (x / 2) ^ (x[0] ? LPOLY : 8'h00);
  endfunction

  function automatic logic [15:0] mstep(input logic [15:0] s, input logic [3:0] d);
    logic [15:0] sh;
    sh = s * 2;
    return sh ^ (s[15] ? MPOLY : 16'h0000) ^ {12'h000, d};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // Advance the reference by one clock edge using the inputs now applied.
  task automatic apply_model();
    exp_t e;
    if (!reset_n) begin
      pos = 0; st = 3'b000; lf = SEED_EFF; sg = '0; pc = 0;
    end else if (pos == 0) begin
      st = core_ns;
`ifdef S27_SCAN_EN
      if (scan_en) st = {st_shift_src(), scan_in};
`endif
      if (start) pos = 1;
    end else if (pos == 1) begin
      st = 3'b000; lf = SEED_EFF; sg = '0; pc = 0; pos = 2;
    end else if (pos <= P + 1) begin
      st = core_ns;
      lf = lstep(lf);
      sg = mstep(sg, {core_po, core_ns});
      if (pc < 255) pc++;
      pos++;
    end else begin
      st = core_ns;
      if (!start) pos = 0;
    end
    e.cpi = (pos >= 1 && pos <= P + 1) ? lf[3:0] : pi;
    e.cst = st;
    e.bsy = (pos >= 1 && pos <= P + 1);
    e.dn  = (pos == P + 2);
    e.p   = core_po;
    e.sg  = sg;
    e.pc  = 8'(pc);
    e.so  = st[2];
    q.push_back(e);
  endtask

`ifdef S27_SCAN_EN
  logic [1:0] st_prev;
  function automatic logic [1:0] st_shift_src();
    return st_prev;
  endfunction
`endif

  // Stimulus: random inputs on the falling edge, expectation queued per edge.
  initial begin
    reset_n = 1'b0; start = 1'b0; pi = '0; core_ns = '0; core_po = 1'b0;
`ifdef S27_SCAN_EN
    scan_en = 1'b0; scan_in = 1'b0; st_prev = '0;
`endif
    apply_model();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clock);
      reset_n = (c < 3) ? 1'b0 : ($urandom_range(0, 299) != 0);
      start   = ($urandom_range(0, 3) != 0);
      pi      = 4'($urandom);
      core_ns = 3'($urandom);
      core_po = 1'($urandom);
`ifdef S27_SCAN_EN
      scan_en = 1'($urandom);
      scan_in = 1'($urandom);
      st_prev = st[1:0];
`endif
      apply_model();
    end
    @(negedge clock);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: after each rising edge, pop the expectation and compare outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() == 0) begin
        check("expectation_available", 0, 1);
      end else begin
        e = q.pop_front();
        check("core_pi",    core_pi,    e.cpi);
        check("core_state", core_state, e.cst);
        check("busy",       busy,       e.bsy);
        check("done",       done,       e.dn);
        check("po",         po,         e.p);
        check("signature",  signature,  e.sg);
        check("pat_cnt",    pat_cnt,    e.pc);
`ifdef S27_SCAN_EN
        check("scan_out",   scan_out,   e.so);
`endif
      end
    end
  end

  // Hard time limit so the bench always ends.
  initial begin
    #((NCYC + 100) * 10);
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "time limit exceeded");
  end

endmodule

// File: doc/s27_bist_wrap.md
Name: s27_bist_wrap

Overview:
Sequential wrapper that sits around the combinational s27 core. It owns the three s27 state flops: it feeds G5/G6/G7 to the core and captures the next-state outputs n11/n16/n21 back from it.
It drives the primary inputs G0..G3, either from pins (functional mode) or from an LFSR (BIST mode), and compacts G17 plus next-state into a MISR signature.
A start/done handshake runs a fixed-length self-test for fault-injection campaigns.

Parameters:
LFSR_W, 8, LFSR width (>=4); core_pi uses lfsr[3:0]
LFSR_POLY, 8'hB8, Galois feedback taps
LFSR_SEED, 8'h01, seed loaded in INIT; all-zero is forced to 1
MISR_W, 16, signature width (>=4)
MISR_POLY, 16'h8016, MISR feedback taps
PATTERNS, 255, number of BIST capture cycles (>=1)

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  BIST request, level
pi  in  4  functional G0..G3 ({G3,G2,G1,G0})
core_pi  out  4  to core G0..G3
core_state  out  3  to core {G7,G6,G5}
core_ns  in  3  from core {n21,n16,n11}
core_po  in  1  from core G17
po  out  1  registered-free copy of core_po
busy  out  1  high in INIT/RUN
done  out  1  BIST complete, held
signature  out  MISR_W  MISR contents
pat_cnt  out  8  patterns applied

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - FSM=IDLE; state reg=3'b000; lfsr=LFSR_SEED; MISR=0; pat_cnt=0; busy=0; done=0.
  - Reset overrides every other action, including mid-RUN. The partial signature is discarded.
- State reg update every cycle except INIT: G5<=n11, G6<=n16, G7<=n21, i.e. core_state<=core_ns.
- core_pi mux: IDLE/DONE -> pi; INIT/RUN -> lfsr[3:0]. po=core_po always (combinational pass).
- FSM:
  - IDLE: start=1 -> INIT.
  - INIT (1 cycle): state reg<=0, lfsr<=seed, MISR<=0, pat_cnt<=0, busy=1 -> RUN.
  - RUN: each cycle lfsr advances, MISR captures, pat_cnt++. On the capture where pat_cnt==PATTERNS-1 -> DONE.
  - DONE: busy=0, done=1; signature frozen; hold until start=0 -> IDLE (done clears on that transition).
- start is ignored in INIT/RUN. Dropping start mid-RUN does not abort the run.
- Latency: start sampled at edge k -> INIT at k+1, first capture at k+1..k+2, done=1 from cycle k+PATTERNS+2.
- LFSR (Galois, right shift): lfsr<=(lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0).
- MISR: sig<=(sig<<1) ^ (sig[MISR_W-1] ? MISR_POLY : 0) ^ {zeros, core_po, core_ns}. Truncate to MISR_W.
- pat_cnt saturates at 255. PATTERNS>255 is out of range (elaboration assertion).
- Outside INIT/RUN, MISR and lfsr hold.

Optional Feature:
S27_SCAN_EN.
- Defined: adds ports scan_en (in, 1), scan_in (in, 1), scan_out (out, 1).
  - In IDLE with scan_en=1, the state reg shifts scan_in->G5->G6->G7 instead of the functional capture.
  - scan_out=G7.
  - scan_en is ignored in INIT/RUN/DONE.
- Undefined: ports absent; state reg has functional capture only.

Decomposition:
- Package s27_bist_pkg:
  - FSM enum (IDLE, INIT, RUN, DONE)
  - default LFSR_POLY/MISR_POLY/LFSR_SEED constants
  - state-bit index constants (G5=0, G6=1, G7=2)
- Sub-module s27_lfsr: generic Galois LFSR with load/enable, instantiated for stimulus. The MISR is inline.

Test Plan:
1. Reset then IDLE, pi=4'hA, core_ns=3'b101 -> core_pi=4'hA same cycle; core_state=3'b101 next cycle; busy=0, done=0.
2. PATTERNS=4, start rises at edge 0 -> busy=1 cycles 1-5; done=1 from cycle 6; pat_cnt=4; done clears one cycle after start=0.
3. Core tied core_ns=3'b001, core_po=0, BIST run -> signature=16'h0001 after 1st capture, 16'h0003 after 2nd.
4. LFSR_SEED=0 -> core_pi in first RUN cycle = 4'h1 (seed forced to 8'h01).
5. reset_n=0 mid-RUN (pat_cnt=2) -> next cycle FSM IDLE, signature=0, core_state=0, busy=0, done=0.
6. S27_SCAN_EN defined, IDLE, scan_en=1, scan_in=1,0,1 over 3 cycles -> core_state={G7,G6,G5}=3'b101, scan_out=1.
